case_conv_sched: RTL and testbench

- Schedules a single shared ASCII case-conversion datapath between two byte-stream requesters.
- Round-robin arbitration at packet granularity; a grant is held until the packet's last byte.
- Per-packet conversion mode is latched at grant. Each byte is converted and presented on a registered valid/ready output stream tagged with its source.
- Sits between the character producers and the downstream text sink.

---
 rtl/case_conv_sched_if.sv | 36 +++
 rtl/case_conv_sched.sv | 173 +++++++++++++++++
 tb/tb_case_conv_sched.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/case_conv_sched_if.sv
// Byte-stream bundle between the two character producers, the case-conversion
// scheduler and the downstream text sink.
interface case_conv_sched_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic [1:0] req0_mode;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic [1:0] req1_mode;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_src;
    logic       out_ready;
    logic       busy;

    modport slave (
        input  req0_valid, req0_data, req0_last, req0_mode,
        input  req1_valid, req1_data, req1_last, req1_mode,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_last, out_src, busy
    );

    modport master (
        output req0_valid, req0_data, req0_last, req0_mode,
        output req1_valid, req1_data, req1_last, req1_mode,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_last, out_src, busy
    );
endinterface

// File: rtl/case_conv_sched.sv
// Packet-granular round-robin scheduler for a shared ASCII case-conversion datapath.
// Optional statistics outputs are enabled by defining CASE_CONV_STATS_EN.
module case_conv_sched #(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    case_conv_sched_if.slave bus
`ifdef CASE_CONV_STATS_EN
    ,
    output logic [15:0]      stat_conv,
    output logic [15:0]      stat_pkts
`endif
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(MAX_LEN - 1);

    // mode[0] selects the to-upper rule, mode[1] the to-lower rule; the letter ranges are disjoint.
    function automatic logic [7:0] conv(input logic [7:0] x, input logic [1:0] mode);
        logic [7:0] y;
        y = x;
        if (mode[0] && (x >= 8'h61) && (x <= 8'h7A)) begin
            y = x - 8'h20;
        end else if (mode[1] && (x >= 8'h41) && (x <= 8'h5A)) begin
            y = x + 8'h20;
        end else begin
            y = x;
        end
        return y;
    endfunction

    state_t           state_r, state_s;
    logic             rr_r;
    logic [1:0]       mode_r;
    logic [LEN_W-1:0] count_r;
    logic             out_valid_r, out_last_r, out_src_r;
    logic [7:0]       out_data_r;

    logic             sel_valid_s, sel_last_s, slot_free_s, accept_s, last_s;
    logic [7:0]       sel_data_s, conv_s;
    logic [1:0]       entry_mode_s;

    assign slot_free_s    = !out_valid_r || bus.out_ready;
    assign bus.req0_ready = (state_r == GRANT0) && slot_free_s;
    assign bus.req1_ready = (state_r == GRANT1) && slot_free_s;
    assign accept_s       = sel_valid_s && slot_free_s;
    assign last_s         = sel_last_s || (count_r == LAST_CNT);
    assign conv_s         = conv(sel_data_s, mode_r);

    // Route the granted requester onto the shared datapath.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = 8'h00;
        sel_last_s  = 1'b0;
        case (state_r)
            GRANT0: begin
                sel_valid_s = bus.req0_valid;
                sel_data_s  = bus.req0_data;
                sel_last_s  = bus.req0_last;
            end
            GRANT1: begin
                sel_valid_s = bus.req1_valid;
                sel_data_s  = bus.req1_data;
                sel_last_s  = bus.req1_last;
            end
            default: begin
                sel_valid_s = 1'b0;
                sel_data_s  = 8'h00;
                sel_last_s  = 1'b0;
            end
        endcase
    end

    // Arbitration and packet-end next-state logic.
    always_comb begin
        state_s      = state_r;
        entry_mode_s = bus.req0_mode;
        case (state_r)
            IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || !rr_r)) begin
                    state_s = GRANT0;
                end else if (bus.req1_valid) begin
                    state_s = GRANT1;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT0, GRANT1: begin
                if (accept_s && last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
        if (state_s == GRANT1) begin
            entry_mode_s = bus.req1_mode;
        end else begin
            entry_mode_s = bus.req0_mode;
        end
    end

    // State, round-robin pointer, latched mode and per-packet byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            rr_r    <= 1'b0;
            mode_r  <= 2'b00;
            count_r <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && (state_s != IDLE)) begin
                mode_r  <= entry_mode_s;
                count_r <= {LEN_W{1'b0}};
                rr_r    <= (state_s == GRANT0);
            end else if (accept_s) begin
                count_r <= count_r + {{(LEN_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Output register: refilled on accept, emptied when drained without a refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_last_r  <= 1'b0;
            out_src_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= conv_s;
            out_last_r  <= last_s;
            out_src_r   <= (state_r == GRANT1);
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_src   = out_src_r;
    assign bus.busy      = (state_r != IDLE);

`ifdef CASE_CONV_STATS_EN
    logic [15:0] stat_conv_r, stat_pkts_r;

    // Saturating counters of altered bytes and of packets handed to the sink.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_conv_r <= 16'h0000;
            stat_pkts_r <= 16'h0000;
        end else begin
            if (accept_s && (conv_s != sel_data_s) && (stat_conv_r != 16'hFFFF)) begin
                stat_conv_r <= stat_conv_r + 16'h0001;
            end
            if (out_valid_r && bus.out_ready && out_last_r && (stat_pkts_r != 16'hFFFF)) begin
                stat_pkts_r <= stat_pkts_r + 16'h0001;
            end
        end
    end

    assign stat_conv = stat_conv_r;
    assign stat_pkts = stat_pkts_r;
`endif
endmodule

// File: tb/tb_case_conv_sched.sv
// Self-checking bench for case_conv_sched: directed scenarios, a conversion
// vector table and randomized streams against a packet-level reference model.
module tb_case_conv_sched;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    case_conv_sched_if bus();
`ifdef CASE_CONV_STATS_EN
    logic [15:0] stat_conv, stat_pkts;
`endif

    case_conv_sched #(.MAX_LEN(MAX), .LEN_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CASE_CONV_STATS_EN
        , .stat_conv(stat_conv)
        , .stat_pkts(stat_pkts)
`endif
    );

    typedef struct packed {logic [7:0] d; logic l; logic [1:0] m;} ib_t;
    typedef struct packed {int cyc; logic src; logic [7:0] d; logic l;} ob_t;
    typedef struct packed {logic [1:0] m; logic [7:0] x; logic [7:0] y;} vec_t;

    ib_t  q0[$], q1[$];
    ob_t  oq[$], eq[$];
    logic [8:0] ex0[$], ex1[$];
    logic [63:0] rdy_mask;
    bit   rand_rdy;
    logic tr_ov[64], tr_r0[64], tr_r1[64], tr_busy[64], tr_os[64];
    logic [7:0] tr_od[64];
    vec_t vt[16];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] ref_conv(input logic [7:0] x, input logic [1:0] m);
        logic is_lc, is_uc;
        is_lc = (x inside {[8'h61:8'h7A]});
        is_uc = (x inside {[8'h41:8'h5A]});
        case (m)
            2'b01:   return is_lc ? x - 8'h20 : x;
            2'b10:   return is_uc ? x + 8'h20 : x;
            2'b11:   return is_lc ? x - 8'h20 : (is_uc ? x + 8'h20 : x);
            default: return x;
        endcase
    endfunction

    task automatic clr();
        q0.delete(); q1.delete(); oq.delete(); eq.delete();
        rdy_mask = {64{1'b1}};
        rand_rdy = 1'b0;
    endtask

    // Drive both requesters from their queues for ncyc cycles, recording what the sink takes.
    task automatic run(input int ncyc);
        logic a0, a1, pv, pr;
        logic [9:0] pout;
        pv = 1'b0; pr = 1'b1; pout = 10'h0;
        for (int c = 0; c < ncyc; c++) begin
            bus.req0_valid = (q0.size() > 0);
            bus.req1_valid = (q1.size() > 0);
            if (q0.size() > 0) begin
                bus.req0_data = q0[0].d; bus.req0_last = q0[0].l; bus.req0_mode = q0[0].m;
            end
            if (q1.size() > 0) begin
                bus.req1_data = q1[0].d; bus.req1_last = q1[0].l; bus.req1_mode = q1[0].m;
            end
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
            else if (c < 64) bus.out_ready = rdy_mask[c];
            else bus.out_ready = 1'b1;
            @(negedge clk);
            if (c < 64) begin
                tr_ov[c] = bus.out_valid; tr_od[c] = bus.out_data; tr_os[c] = bus.out_src;
                tr_r0[c] = bus.req0_ready; tr_r1[c] = bus.req1_ready; tr_busy[c] = bus.busy;
            end
            if (pv && !pr) chk($sformatf("stall_hold_c%0d", c),
                               {22'h0, bus.out_valid, bus.out_data, bus.out_last}, {22'h0, 1'b1, pout[9:1]});
            if (bus.req0_ready && bus.req1_ready) chk($sformatf("ready_excl_c%0d", c), 32'h1, 32'h0);
            if (bus.out_valid && bus.out_ready) oq.push_back('{c, bus.out_src, bus.out_data, bus.out_last});
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            pv = bus.out_valid; pr = bus.out_ready;
            pout = {bus.out_data, bus.out_last, bus.out_src};
            @(posedge clk); #1;
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic chk_oq(input string tn);
        chk({tn, "_count"}, oq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < oq.size(); i++) begin
            chk($sformatf("%s_cyc%0d", tn, i), oq[i].cyc, eq[i].cyc);
            chk($sformatf("%s_src%0d", tn, i), {31'h0, oq[i].src}, {31'h0, eq[i].src});
            chk($sformatf("%s_data%0d", tn, i), {24'h0, oq[i].d}, {24'h0, eq[i].d});
            chk($sformatf("%s_last%0d", tn, i), {31'h0, oq[i].l}, {31'h0, eq[i].l});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    // Expected per-source streams: segments end on last or after MAX bytes, mode taken at segment start.
    task automatic build_model(input ib_t src_q[$], output logic [8:0] ex[$]);
        int seg;
        logic [1:0] sm;
        logic l;
        seg = 0; sm = 2'b00;
        ex.delete();
        foreach (src_q[i]) begin
            if (seg == 0) sm = src_q[i].m;
            l = src_q[i].l || (seg == MAX - 1);
            ex.push_back({ref_conv(src_q[i].d, sm), l});
            seg = l ? 0 : seg + 1;
        end
    endtask

    task automatic random_round(input int it);
        ib_t e;
        int len;
        logic [1:0] pm;
        logic [8:0] x;
        clr();
        rand_rdy = 1'b1;
        for (int n = 0; n < 2; n++) begin
            for (int p = 0; p < 6; p++) begin
                len = $urandom_range(1, 7);
                pm = 2'($urandom_range(0, 3));
                for (int b = 0; b < len; b++) begin
                    e.d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(64, 127)) : 8'($urandom_range(0, 255));
                    e.l = (b == len - 1);
                    e.m = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : pm;
                    if (n == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
        end
        build_model(q0, ex0);
        build_model(q1, ex1);
        run(600);
        chk($sformatf("rnd%0d_q0_drained", it), q0.size(), 0);
        chk($sformatf("rnd%0d_q1_drained", it), q1.size(), 0);
        for (int i = 0; i < oq.size(); i++) begin
            if (i > 0 && oq[i].src != oq[i-1].src)
                chk($sformatf("rnd%0d_no_interleave%0d", it, i), {31'h0, oq[i-1].l}, 32'h1);
            if (oq[i].src == 1'b0 && ex0.size() > 0) begin
                x = ex0.pop_front();
                chk($sformatf("rnd%0d_src0_byte%0d", it, i), {23'h0, oq[i].d, oq[i].l}, {23'h0, x});
            end else if (oq[i].src == 1'b1 && ex1.size() > 0) begin
                x = ex1.pop_front();
                chk($sformatf("rnd%0d_src1_byte%0d", it, i), {23'h0, oq[i].d, oq[i].l}, {23'h0, x});
            end else begin
                chk($sformatf("rnd%0d_extra_byte%0d", it, i), {31'h0, oq[i].src}, 32'hFFFF_FFFF);
            end
        end
        chk($sformatf("rnd%0d_ex0_left", it), ex0.size(), 0);
        chk($sformatf("rnd%0d_ex1_left", it), ex1.size(), 0);
    endtask

    initial begin
        vt[0]  = '{2'b00, 8'h61, 8'h61}; vt[1]  = '{2'b01, 8'h61, 8'h41};
        vt[2]  = '{2'b01, 8'h7A, 8'h5A}; vt[3]  = '{2'b01, 8'h7B, 8'h7B};
        vt[4]  = '{2'b01, 8'h60, 8'h60}; vt[5]  = '{2'b01, 8'h41, 8'h41};
        vt[6]  = '{2'b10, 8'h41, 8'h61}; vt[7]  = '{2'b10, 8'h5A, 8'h7A};
        vt[8]  = '{2'b10, 8'h40, 8'h40}; vt[9]  = '{2'b10, 8'h5B, 8'h5B};
        vt[10] = '{2'b10, 8'hC1, 8'hC1}; vt[11] = '{2'b11, 8'h61, 8'h41};
        vt[12] = '{2'b11, 8'h41, 8'h61}; vt[13] = '{2'b11, 8'hE1, 8'hE1};
        vt[14] = '{2'b11, 8'h30, 8'h30}; vt[15] = '{2'b00, 8'h5A, 8'h5A};

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0; bus.req0_mode = 2'b00;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0; bus.req1_mode = 2'b00;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_out_data", {24'h0, bus.out_data}, 32'h0);
        chk("rst_out_last", {31'h0, bus.out_last}, 32'h0);
        chk("rst_out_src", {31'h0, bus.out_src}, 32'h0);
        chk("rst_req_ready", {30'h0, bus.req0_ready, bus.req1_ready}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single packet "abZ!" in upper mode: one byte per cycle, 1-cycle latency.
        clr();
        q0 = '{'{8'h61, 1'b0, 2'b01}, '{8'h62, 1'b0, 2'b01}, '{8'h5A, 1'b0, 2'b01}, '{8'h21, 1'b1, 2'b01}};
        eq = '{'{2, 1'b0, 8'h41, 1'b0}, '{3, 1'b0, 8'h42, 1'b0}, '{4, 1'b0, 8'h5A, 1'b0}, '{5, 1'b0, 8'h21, 1'b1}};
        run(8);
        chk_oq("single");
        chk("single_idle_no_ready", {31'h0, tr_r0[0]}, 32'h0);
        chk("single_busy", {31'h0, tr_busy[1]}, 32'h1);
`ifdef CASE_CONV_STATS_EN
        chk("stat_conv", {16'h0, stat_conv}, 32'd2);
        chk("stat_pkts", {16'h0, stat_pkts}, 32'd1);
`endif

        // Contention straight from reset: req0 first, bubble, then req1.
        do_reset();
        clr();
        q0 = '{'{8'h10, 1'b0, 2'b00}, '{8'h11, 1'b1, 2'b00}};
        q1 = '{'{8'h20, 1'b0, 2'b00}, '{8'h21, 1'b1, 2'b00}};
        eq = '{'{2, 1'b0, 8'h10, 1'b0}, '{3, 1'b0, 8'h11, 1'b1}, '{5, 1'b1, 8'h20, 1'b0}, '{6, 1'b1, 8'h21, 1'b1}};
        run(10);
        chk_oq("contend");
        clr();
        q0 = '{'{8'h30, 1'b1, 2'b00}};
        q1 = '{'{8'h31, 1'b1, 2'b00}};
        eq = '{'{2, 1'b0, 8'h30, 1'b1}, '{4, 1'b1, 8'h31, 1'b1}};
        run(8);
        chk_oq("contend_again");
        clr();
        q0 = '{'{8'h60, 1'b1, 2'b00}};
        run(4);
        clr();
        q0 = '{'{8'h61, 1'b1, 2'b00}};
        q1 = '{'{8'h62, 1'b1, 2'b00}};
        eq = '{'{2, 1'b1, 8'h62, 1'b1}, '{4, 1'b0, 8'h61, 1'b1}};
        run(8);
        chk_oq("rr_after_req0");

        // Backpressure in swap mode: first byte held for three stalled cycles.
        clr();
        rdy_mask = ~64'h1C;
        q0 = '{'{8'h61, 1'b0, 2'b11}, '{8'h42, 1'b1, 2'b11}};
        eq = '{'{5, 1'b0, 8'h41, 1'b0}, '{6, 1'b0, 8'h62, 1'b1}};
        run(9);
        chk_oq("bp");
        for (int c = 2; c <= 4; c++) begin
            chk($sformatf("bp_hold_c%0d", c), {23'h0, tr_ov[c], tr_od[c]}, {23'h0, 1'b1, 8'h41});
            chk($sformatf("bp_ready0_c%0d", c), {31'h0, tr_r0[c]}, 32'h0);
        end
        chk("bp_ready_resume", {31'h0, tr_r0[5]}, 32'h1);

        // Forced packet end after MAX bytes, then re-arbitration bubble.
        clr();
        for (int i = 0; i < 6; i++) q1.push_back('{8'(8'h61 + i), (i == 5), 2'b01});
        eq = '{'{2, 1'b1, 8'h41, 1'b0}, '{3, 1'b1, 8'h42, 1'b0}, '{4, 1'b1, 8'h43, 1'b0},
               '{5, 1'b1, 8'h44, 1'b1}, '{7, 1'b1, 8'h45, 1'b0}, '{8, 1'b1, 8'h46, 1'b1}};
        run(11);
        chk_oq("maxlen");

        // Mode latched at grant; non-letters unchanged.
        clr();
        q0 = '{'{8'h41, 1'b0, 2'b10}, '{8'h80, 1'b0, 2'b00}, '{8'h7B, 1'b1, 2'b00}};
        eq = '{'{2, 1'b0, 8'h61, 1'b0}, '{3, 1'b0, 8'h80, 1'b0}, '{4, 1'b0, 8'h7B, 1'b1}};
        run(7);
        chk_oq("mode_latch");
        clr();
        q0 = '{'{8'h41, 1'b0, 2'b10}, '{8'h42, 1'b1, 2'b00}};
        eq = '{'{2, 1'b0, 8'h61, 1'b0}, '{3, 1'b0, 8'h62, 1'b1}};
        run(6);
        chk_oq("mode_latch2");

        // Conversion vector table, one single-byte packet per entry.
        foreach (vt[i]) begin
            clr();
            q0.push_back('{vt[i].x, 1'b1, vt[i].m});
            run(4);
            chk($sformatf("conv_vec%0d", i), (oq.size() == 1) ? {24'h0, oq[0].d} : 32'hFFFF_FFFF, {24'h0, vt[i].y});
        end

        // Reset while GRANT1 holds a stalled byte.
        clr();
        rdy_mask = 64'h0;
        q1 = '{'{8'h61, 1'b0, 2'b00}, '{8'h62, 1'b0, 2'b00}, '{8'h63, 1'b0, 2'b00}};
        run(4);
        chk("midrst_pre", {29'h0, tr_busy[3], tr_ov[3], tr_os[3]}, 32'h7);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk); #1;
        clr();
        q0 = '{'{8'h50, 1'b1, 2'b00}};
        q1 = '{'{8'h51, 1'b1, 2'b00}};
        eq = '{'{2, 1'b0, 8'h50, 1'b1}, '{4, 1'b1, 8'h51, 1'b1}};
        run(7);
        chk_oq("midrst_regrant");

        for (int it = 0; it < 4; it++) random_round(it);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
